muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32x32 shift-add multiplier and restoring divider feeding HI/LO.
// Define MULDIV_DIV_EN to build the divider, the DIV state and div_by_zero reporting.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] Hi_out,
    output logic [31:0] Lo_out
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
`else
    typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;
`endif

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opnd_q, opnd_d;
    logic        neg_lo_q, neg_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
`ifdef MULDIV_DIV_EN
    logic        neg_hi_q, neg_hi_d;
    logic        is_div_q, is_div_d;
    logic        dbz_q, dbz_d;
    logic [32:0] div_shift;
    logic        div_ok;
    logic [31:0] div_rem;
`endif

    logic        is_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] prod_fix;

    // acc holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        a_neg     = is_signed & A[31];
        b_neg     = is_signed & B[31];
        a_mag     = a_neg ? (32'd0 - A) : A;
        b_mag     = b_neg ? (32'd0 - B) : B;
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        prod_fix  = neg_lo_q ? (64'd0 - acc_q) : acc_q;
`ifdef MULDIV_DIV_EN
        div_shift = acc_q[63:31];
        div_ok    = (div_shift >= {1'b0, opnd_q});
        div_rem   = div_shift[31:0] - opnd_q;
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULDIV_DIV_EN
        neg_hi_d = neg_hi_q;
        is_div_d = is_div_q;
        dbz_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            acc_d    = {32'd0, a_mag};
                            opnd_d   = b_mag;
                            neg_lo_d = a_neg ^ b_neg;
                            cnt_d    = 5'd0;
                            state_d  = MUL;
`ifdef MULDIV_DIV_EN
                            is_div_d = 1'b0;
`endif
                        end
`ifdef MULDIV_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            // A zero divisor reports immediately and leaves HI/LO alone
                            if (B == 32'd0) begin
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                acc_d    = {32'd0, a_mag};
                                opnd_d   = b_mag;
                                neg_lo_d = a_neg ^ b_neg;
                                neg_hi_d = a_neg;
                                is_div_d = 1'b1;
                                cnt_d    = 5'd0;
                                state_d  = DIV;
                            end
                        end
`else
                        OP_DIV, OP_DIVU: ;
`endif
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
`ifdef MULDIV_DIV_EN
            DIV: begin
                acc_d = div_ok ? {div_rem, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
`endif
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
                if (is_div_q) begin
                    lo_d = neg_lo_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
                    hi_d = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
                end else
`endif
                begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            acc_q    <= 64'd0;
            opnd_q   <= 32'd0;
            neg_lo_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            dbz_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_lo_q <= neg_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULDIV_DIV_EN
            neg_hi_q <= neg_hi_d;
            is_div_q <= is_div_d;
            dbz_q    <= dbz_d;
`endif
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign Hi_out = hi_q;
    assign Lo_out = lo_q;
`ifdef MULDIV_DIV_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule
